// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, status flag bit positions and FSM state encodings
// shared by seq_alu, seq_muldiv and the testbench.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_REM = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_NOT = 4'd8,
        OP_LSL = 4'd9,
        OP_LSR = 4'd10,
        OP_ASR = 4'd11
    } op_e;

    // statusOut = {N, Z, C, V}
    localparam int ST_N = 3;
    localparam int ST_Z = 2;
    localparam int ST_C = 1;
    localparam int ST_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Opcodes executed by the iterative multiply/divide unit.
    function automatic logic is_long(logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative unsigned shift-add multiplier / restoring divider,
// one bit per cycle, WIDTH iterations per operation.
//   clk, rst_n   : clock, async active-low reset
//   start_i      : load operands and begin (ignored by caller while busy)
//   is_mul_i     : 1 = multiply a_i*b_i, 0 = divide a_i/b_i
//   done_o       : high during the final iteration cycle; hi_o/lo_o then
//                  carry the finished values, valid for capture at that edge
//   lo_o / hi_o  : multiply -> product low/high half; divide -> quotient/remainder
module seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             is_mul_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);
    localparam int CW = $clog2(WIDTH);

    // hi/lo double as {partial product} for multiply and {remainder, dividend/quotient}
    // for divide; opnd is the multiplicand or divisor.
    logic             busy_q, busy_d;
    logic             mul_q, mul_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [WIDTH:0]   sum, trial, diff;
    logic [WIDTH-1:0] step_hi, step_lo;

    always_comb begin
        sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
        trial = {hi_q, lo_q[WIDTH-1]};
        diff  = trial - {1'b0, opnd_q};
        if (mul_q) begin
            step_hi = sum[WIDTH:1];
            step_lo = {sum[0], lo_q[WIDTH-1:1]};
        end else if (trial >= {1'b0, opnd_q}) begin
            // diff < opnd here, so it fits in WIDTH bits. A zero divisor always
            // takes this path: quotient all-ones, remainder = dividend.
            step_hi = diff[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = trial[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign hi_o   = step_hi;
    assign lo_o   = step_lo;

    always_comb begin
        busy_d = busy_q;
        mul_d  = mul_q;
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        if (start_i) begin
            busy_d = 1'b1;
            mul_d  = is_mul_i;
            cnt_d  = '0;
            hi_d   = '0;
            lo_d   = is_mul_i ? b_i : a_i;
            opnd_d = is_mul_i ? a_i : b_i;
        end else if (busy_q) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + 1'b1;
            if (done_o) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            mul_q  <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
        end else begin
            busy_q <= busy_d;
            mul_q  <= mul_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with valid/ready handshakes. Single-cycle ops finish
// one cycle after accept; MUL/DIV/REM run on seq_muldiv and finish WIDTH+1
// cycles after accept.
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : request handshake (opcode, operand1, operand2)
//   out_valid / out_ready : response handshake (result, statusOut = {N,Z,C,V})
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       statusOut
);
    localparam int SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       stat_q, stat_d;
    logic [3:0]       op_q;
    logic             dz_q;

    logic             accept, long_op, md_start, md_done;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic [WIDTH-1:0] sc_res, lg_res;
    logic             sc_c, sc_v, lg_c, lg_v;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   add_t, lsl_t, lsr_t, asr_t;
    logic [WIDTH-1:0] sub_t;

    function automatic logic [3:0] mk_stat(logic [WIDTH-1:0] r, logic c, logic v);
        logic [3:0] s;
        s       = '0;
        s[ST_N] = r[WIDTH-1];
        s[ST_Z] = (r == '0);
        s[ST_C] = c;
        s[ST_V] = v;
        return s;
    endfunction

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign statusOut = stat_q;
    assign accept    = in_valid && in_ready;
    assign long_op   = is_long(opcode);
    assign md_start  = accept && long_op;

    // Shifts are done one bit wider so the last bit shifted out lands in a
    // fixed position (0 when the amount is 0).
    assign sh    = operand2[SHW-1:0];
    assign add_t = {1'b0, operand1} + {1'b0, operand2};
    assign sub_t = operand1 - operand2;
    assign lsl_t = {1'b0, operand1} << sh;
    assign lsr_t = {operand1, 1'b0} >> sh;
    assign asr_t = $signed({operand1, 1'b0}) >>> sh;

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (opcode)
            OP_ADD: begin
                sc_res = add_t[WIDTH-1:0];
                sc_c   = add_t[WIDTH];
                sc_v   = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                         (sc_res[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_t;
                sc_c   = (operand1 >= operand2);
                sc_v   = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                         (sc_res[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_AND: sc_res = operand1 & operand2;
            OP_OR:  sc_res = operand1 | operand2;
            OP_XOR: sc_res = operand1 ^ operand2;
            OP_NOT: sc_res = ~operand1;
            OP_LSL: begin
                sc_res = lsl_t[WIDTH-1:0];
                sc_c   = lsl_t[WIDTH];
            end
            OP_LSR: begin
                sc_res = lsr_t[WIDTH:1];
                sc_c   = lsr_t[0];
            end
            OP_ASR: begin
                sc_res = asr_t[WIDTH:1];
                sc_c   = asr_t[0];
            end
            default: ; // undefined opcodes: result 0, only Z set by mk_stat
        endcase
    end

    // Completion of a MUL/DIV/REM; divide-by-zero values fall out of the
    // restoring divider, only V needs the captured zero-divisor flag.
    always_comb begin
        lg_res = (op_q == OP_REM) ? md_hi : md_lo;
        lg_c   = (op_q == OP_MUL) && (md_hi != '0);
        lg_v   = (op_q == OP_MUL) ? (md_hi != '0) : dz_q;
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        stat_d  = stat_q;
        case (state_q)
            IDLE: ;
            BUSY: if (md_done) begin
                state_d = DONE;
                res_d   = lg_res;
                stat_d  = mk_stat(lg_res, lg_c, lg_v);
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // accept is only possible from IDLE or a DONE being drained
        if (accept) begin
            state_d = long_op ? BUSY : DONE;
            if (!long_op) begin
                res_d  = sc_res;
                stat_d = mk_stat(sc_res, sc_c, sc_v);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            stat_q  <= '0;
            op_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            stat_q  <= stat_d;
            if (accept) begin
                op_q <= opcode;
                dz_q <= (operand2 == '0);
            end
        end
    end

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (md_start),
        .is_mul_i (opcode == OP_MUL),
        .a_i      (operand1),
        .b_i      (operand2),
        .done_o   (md_done),
        .lo_o     (md_lo),
        .hi_o     (md_hi)
    );

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=8: the driver pushes hand-computed
// expectations on each accepted request; the monitor checks latency, result
// and flags whenever out_valid is high and pops on out_ready.
module tb_seq_alu;
    import alu_pkg::*;
    localparam int W = 8;

    logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]   opcode, statusOut;
    logic [W-1:0] operand1, operand2, result;

    typedef struct {
        logic [W-1:0] r;
        logic [3:0]   s;
        int           lat;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   seen   = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .operand1  (operand1),
        .operand2  (operand2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .statusOut (statusOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: result %0h with empty scoreboard", result);
            end else begin
                if (!seen) begin
                    chk("latency", cyc - q[0].acc, q[0].lat);
                    seen = 1;
                end
                chk("result", result, q[0].r);
                chk("status", statusOut, q[0].s);
                if (out_ready) begin
                    void'(q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic issue(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b,
                         logic [W-1:0] er, logic [3:0] es);
        int n = 0;
        exp_t e;
        opcode   = op;
        operand1 = a;
        operand2 = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready %0b, required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            e.r   = er;
            e.s   = es;
            e.lat = is_long(op) ? W + 1 : 1;
            e.acc = cyc;
            q.push_back(e);
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; operand1 = '0; operand2 = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_status", statusOut, 0);
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("rst_in_ready", in_ready, 1);

        // Arithmetic and flags
        issue(OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b1001);
        issue(OP_SUB, 8'h00, 8'h01, 8'hFF, 4'b1000);
        issue(OP_MUL, 8'h10, 8'h10, 8'h00, 4'b0111);
        issue(OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0110);
        issue(OP_MUL, 8'h0F, 8'h0B, 8'hA5, 4'b1000);
        issue(OP_DIV, 8'd200, 8'd7, 8'd28, 4'b0000);
        issue(OP_REM, 8'd200, 8'd7, 8'd4, 4'b0000);
        issue(OP_DIV, 8'd200, 8'd0, 8'hFF, 4'b1001);
        issue(OP_REM, 8'd200, 8'd0, 8'd200, 4'b1001);
        // Shifts, including amount 0 and ignored upper amount bits
        issue(OP_ASR, 8'h90, 8'd2, 8'hE4, 4'b1000);
        issue(OP_LSL, 8'h81, 8'd1, 8'h02, 4'b0010);
        issue(OP_LSR, 8'h81, 8'h09, 8'h40, 4'b0010);
        issue(OP_LSL, 8'h81, 8'h00, 8'h81, 4'b1000);
        // Undefined opcode
        issue(4'd13, 8'h05, 8'h06, 8'h00, 4'b0100);
        drain();

        // Backpressure: result held, input ignored for 5 cycles
        out_ready = 1'b0;
        issue(OP_ADD, 8'h01, 8'h02, 8'h03, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            opcode = OP_ADD; operand1 = 8'h09; operand2 = 8'h09; in_valid = 1'b1;
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk); #2;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Back-to-back single-cycle ops: one per cycle
        c0 = cyc;
        issue(OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000);
        issue(OP_OR,  8'hF0, 8'h0F, 8'hFF, 4'b1000);
        issue(OP_XOR, 8'hAA, 8'hAA, 8'h00, 4'b0100);
        issue(OP_NOT, 8'h0F, 8'h00, 8'hF0, 4'b1000);
        chk("b2b_cycles", cyc - c0, 4);
        drain();

        // Reset in the 4th cycle of a divide
        issue(OP_DIV, 8'd200, 8'd7, 8'd28, 4'b0000);
        repeat (3) begin
            @(posedge clk); #2;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_status", statusOut, 0);
        q.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("midrst_in_ready", in_ready, 1);
        repeat (12) begin
            @(posedge clk); #2;
        end
        chk("midrst_no_stale", out_valid, 0);
        issue(OP_SUB, 8'd5, 8'd3, 8'd2, 4'b0010);
        issue(OP_DIV, 8'd100, 8'd9, 8'd11, 4'b0000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand/result width in bits (legal range 4..64).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, the request is valid.
REQ-005 SHALL have port in_ready, output, 1, the block accepts a request this cycle.
REQ-006 SHALL have port opcode, input, 4, the operation select.
REQ-007 SHALL have ports operand1 and operand2, input, WIDTH each, the operands.
REQ-008 SHALL have port out_valid, output, 1, result/statusOut are valid.
REQ-009 SHALL have port out_ready, input, 1, the consumer takes the result.
REQ-010 SHALL have port result, output, WIDTH, the operation result.
REQ-011 SHALL have port statusOut, output, 4, flags {N,Z,C,V} with N at bit 3 and V at bit 0.

Function
REQ-012 SHALL accept a request on a cycle with in_valid && in_ready; operands and opcode are captured that cycle.
REQ-013 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-014 SHALL use the FSM states IDLE, BUSY and DONE.
- IDLE->DONE on accepting a single-cycle op.
- IDLE->BUSY on accepting MUL/DIV/REM.
- BUSY->DONE after WIDTH iterations.
- DONE->IDLE on out_ready without a new accept.
- DONE->DONE/BUSY on out_ready with a same-cycle accept.
REQ-015 SHALL decode opcodes as ADD 0, SUB 1, MUL 2, DIV 3, REM 4, AND 5, OR 6, XOR 7, NOT 8 (~operand1), LSL 9, LSR 10, ASR 11; 12..15 are undefined.
REQ-016 SHALL assert out_valid exactly 1 cycle after accept for single-cycle ops and WIDTH+1 cycles after accept for MUL/DIV/REM.
REQ-017 SHALL hold result and statusOut stable while out_valid && !out_ready.
REQ-018 SHALL treat MUL, DIV and REM as unsigned: iterative shift-add multiply and restoring divide, one bit per cycle; MUL returns the low WIDTH bits.
REQ-019 SHALL use operand2[$clog2(WIDTH)-1:0] as the shift amount; all other bits of operand2 are ignored for shifts.
REQ-020 SHALL compute N = result[WIDTH-1] and Z = (result==0) for every opcode.
REQ-021 SHALL set C and V as follows:
- ADD: C = carry out; V = signed overflow.
- SUB: C = no borrow (operand1 >= operand2 unsigned); V = signed overflow.
- MUL: C = V = (upper product half != 0).
- Shifts: C = last bit shifted out (0 when the amount is 0); V = 0.
- AND/OR/XOR/NOT: C = V = 0.
REQ-022 SHALL handle divide-by-zero as follows: DIV returns all-ones, REM returns operand1, V = 1, C = 0; it takes the same latency as a normal divide.
REQ-023 SHALL return result 0 and flags N=0 Z=1 C=0 V=0 for undefined opcodes, with single-cycle latency.
REQ-024 SHALL ignore in_valid while BUSY, or while in DONE with out_ready low.

Reset
REQ-025 SHALL, on rst_n low, immediately force state=IDLE, out_valid=0, result=0, statusOut=0 and clear the iteration counter, aborting any in-flight operation.
REQ-026 SHALL assert in_ready=1 on the first rising clk edge after rst_n deasserts.

Structure
REQ-027 SHALL take opcode encodings, status bit indices and state encodings from a shared package/include (alu_pkg), also used by the testbench.
REQ-028 SHALL place the iterative multiply/divide datapath (counter, partial product/remainder, quotient) in one sub-module, seq_muldiv, with start/done handshake to the parent.

Verification (WIDTH=8)
REQ-029 SHALL cover: ADD 8'h7F+8'h01 -> result 8'h80, statusOut 4'b1001, out_valid 1 cycle after accept.
REQ-030 SHALL cover: SUB 8'h00-8'h01 -> result 8'hFF, N=1 C=0 V=0; then MUL 8'h10*8'h10 -> result 8'h00, Z=1 C=1 V=1, out_valid 9 cycles after accept.
REQ-031 SHALL cover: DIV 8'd200/8'd7 -> 8'd28; REM -> 8'd4; DIV by 0 -> result 8'hFF with V=1 and REM by 0 -> 8'd200.
REQ-032 SHALL cover: ASR 8'h90 by 2 -> 8'hE4 with C=0; LSL 8'h81 by 1 -> 8'h02 with C=1; operand2=8'h09 on an 8-bit shift uses amount 1.
REQ-033 SHALL cover backpressure: out_ready held low 5 cycles -> result stable, in_ready=0, new requests ignored; back-to-back single-cycle ops with out_ready=1 -> one result per cycle.
REQ-034 SHALL cover reset mid-DIV at cycle 4 -> out_valid=0 immediately, no stale result, next op correct.
